uart_rx_cfg: RTL

//  Parametrised UART receiver; successor to the fixed 8N1 receive path. Contains:
//   - integrated oversampling tick generator;
//   - 2-FF input synchroniser;
//   - 3-sample majority vote at mid-bit;
//   - configurable data bits, parity and stop bits;
//   - single-word output holding register with valid/ready handshake;
//   - per-word parity/frame error qualifiers and an overrun pulse.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_cfg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding, baud divider helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  // Clocks per oversample tick, truncated; shared with the transmit side.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: 1-cycle tick every DIV clocks while enabled.
// Latency: first tick DIV clocks after en rises; counter held at 0 while en is low.
// Backpressure: none; free-running while enabled.
// Ports: clk, rst_n (async active-low), en (run enable), tick (1-cycle pulse).
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int TW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [TW-1:0] LAST = TW'(DIV - 1);

  if (DIV < 2) begin : g_div_chk
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [TW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop bits).
// Latency: word committed at mid-point of the last stop bit; outputs registered 1 clk later.
// Backpressure: single holding register; a word arriving while the old one is unread is dropped (overrun).
// Ports: clk, rst_n (async active-low), data_rx (serial in, idle high),
//        rx_data/rx_valid/rx_ready (word handshake), parity_err/frame_err (per-word flags),
//        overrun/over_rx (commit pulses), busy (receiver not idle).
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 over_rx,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [SW-1:0] S_MID_M1 = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_RES    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_chk
    $error("uart_rx_cfg: parameter out of range");
  end

  uart_state_t          state, state_nxt;
  logic                 rx_meta, rx_sync, rx_prev;
  logic                 tick, resolve, wrap, bit_val, fall, commit, drop;
  logic [SW-1:0]        s_cnt;
  logic [BW-1:0]        bit_cnt;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_acc, ferr_acc;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state != ST_IDLE),
    .tick  (tick)
  );

  // Synchroniser plus one history flop; a start needs a high-to-low transition,
  // so a line held low (break) cannot retrigger until it has returned high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= data_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall    = rx_prev && !rx_sync;
  assign resolve = tick && (s_cnt == S_RES);
  assign wrap    = tick && (s_cnt == S_LAST);
  // Third sample is taken live on the resolve tick.
  assign bit_val = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
  assign drop    = rx_valid && !rx_ready;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      ST_IDLE:   if (fall) state_nxt = ST_START;
      ST_START: begin
        if (resolve && bit_val) state_nxt = ST_IDLE;
        else if (wrap)          state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (wrap && bit_cnt == LAST_DATA)
          state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (wrap) state_nxt = ST_STOP;
      ST_STOP: begin
        // Commit mid-bit so the next start edge is never missed.
        if (resolve && bit_cnt == LAST_STOP) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt    <= '0;
      bit_cnt  <= '0;
      samp_a   <= 1'b1;
      samp_b   <= 1'b1;
      shreg    <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (state == ST_IDLE)  s_cnt <= '0;
      else if (wrap)         s_cnt <= '0;
      else if (tick)         s_cnt <= s_cnt + SW'(1);

      if (state_nxt != state) bit_cnt <= '0;
      else if (wrap)          bit_cnt <= bit_cnt + BW'(1);

      if (tick && s_cnt == S_MID_M1) samp_a <= rx_sync;
      if (tick && s_cnt == S_MID)    samp_b <= rx_sync;

      if (state == ST_DATA && resolve) shreg <= {bit_val, shreg[DATA_BITS-1:1]};

      if (state == ST_IDLE) begin
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end else begin
        // Total ones over data+parity: odd mode wants 1, even mode wants 0.
        if (state == ST_PARITY && resolve)
          perr_acc <= (PARITY == PAR_ODD) ? !(^shreg ^ bit_val) : (^shreg ^ bit_val);
        if (state == ST_STOP && resolve && !bit_val)
          ferr_acc <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      over_rx    <= 1'b0;
    end else begin
      over_rx <= commit;
      overrun <= commit && drop;
      if (commit && !drop) begin
        rx_data    <= shreg;
        parity_err <= perr_acc;
        frame_err  <= ferr_acc | !bit_val;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
